// File: rtl/fw_ip2_pkg.sv
// Shared constants and types for the fw_ip2 scan-chain readback path.
package fw_ip2_pkg;

    localparam int WORD_W   = 32;
    localparam int N_WORDS  = 24;
    localparam int CNT_W    = 10;
    localparam int AW       = 5;
    localparam int MAX_BITS = N_WORDS * WORD_W;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RE,
        DELAY,
        SAMPLE,
        FLUSH,
        DONE
    } rx_state_t;

endpackage

// File: rtl/fw_ip2_sync2.sv
// Generic 2-FF synchroniser for asynchronous chip inputs; 2-cycle latency.
module fw_ip2_sync2 #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/fw_ip2_scan_out_rx.sv
// Scan-out receiver: samples fw_scan_out a programmable delay after each bxclk
// rising edge and packs the bits LSB-first into a word buffer read by SW.
module fw_ip2_scan_out_rx
    import fw_ip2_pkg::*;
(
    input  logic              fw_pl_clk1,
    input  logic              fw_rst,
    input  logic              cfg_start,
    input  logic              cfg_abort,
    input  logic [CNT_W-1:0]  cfg_num_bits,
    input  logic [5:0]        cfg_sample_dly,
    input  logic              bxclk_re,
    input  logic              fw_scan_out,
    input  logic [AW-1:0]     rd_addr,
    output logic [WORD_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              err_late,
    output logic [CNT_W-1:0]  bits_captured
);

    localparam int BW = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_BITS);

    logic              sample;
    rx_state_t         state_q;
    logic [CNT_W-1:0]  n_q;
    logic [CNT_W-1:0]  bits_q;
    logic [5:0]        dly_q;
    logic [WORD_W-1:0] shreg_q;
    logic              sample_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [WORD_W-1:0] rd_data_q;
    logic [WORD_W-1:0] mem [N_WORDS];

    logic [CNT_W-1:0]  n_d;
    logic [BW-1:0]     bit_idx;
    logic              last_bit;
    logic [WORD_W-1:0] shreg_d;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;

    fw_ip2_sync2 #(.W(1)) u_sync_scan (
        .clk_i (fw_pl_clk1),
        .rst_i (fw_rst),
        .d_i   (fw_scan_out),
        .q_o   (sample)
    );

    assign n_d      = (cfg_num_bits > MAX_N) ? MAX_N : cfg_num_bits;
    assign bit_idx  = bits_q[BW-1:0];
    assign last_bit = (bits_q + CNT_W'(1)) >= n_q;
    assign shreg_d  = shreg_q | (WORD_W'(sample_q) << bit_idx);
    assign wr_addr  = AW'(bits_q >> BW);
    // Abort and reset win over a write falling in the same cycle.
    assign wr_en    = (state_q == SAMPLE) && !fw_rst && !cfg_abort &&
                      ((bit_idx == BW'(WORD_W - 1)) || last_bit);

    always_ff @(posedge fw_pl_clk1) begin
        if (fw_rst) begin
            state_q  <= IDLE;
            n_q      <= '0;
            bits_q   <= '0;
            dly_q    <= '0;
            shreg_q  <= '0;
            sample_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else if (cfg_abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            shreg_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (cfg_start) begin
                        n_q     <= n_d;
                        bits_q  <= '0;
                        err_q   <= 1'b0;
                        done_q  <= 1'b0;
                        shreg_q <= '0;
                        if (n_d == '0) begin
                            state_q <= FLUSH;
                        end else begin
                            state_q <= WAIT_RE;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                WAIT_RE: begin
                    if (bxclk_re) begin
                        dly_q <= cfg_sample_dly;
                        if (cfg_sample_dly == '0) begin
                            sample_q <= sample;
                            state_q  <= SAMPLE;
                        end else begin
                            state_q <= DELAY;
                        end
                    end
                end
                DELAY: begin
                    // A new bxclk edge before the sample point retries the same bit.
                    if (bxclk_re) begin
                        err_q <= 1'b1;
                        dly_q <= cfg_sample_dly;
                        if (cfg_sample_dly == '0) begin
                            sample_q <= sample;
                            state_q  <= SAMPLE;
                        end
                    end else if (dly_q <= 6'd1) begin
                        sample_q <= sample;
                        state_q  <= SAMPLE;
                    end else begin
                        dly_q <= dly_q - 6'd1;
                    end
                end
                SAMPLE: begin
                    if (bits_q != n_q) bits_q <= bits_q + CNT_W'(1);
                    shreg_q <= wr_en ? '0 : shreg_d;
                    state_q <= last_bit ? FLUSH : WAIT_RE;
                end
                FLUSH: begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge fw_pl_clk1) begin
        if (wr_en) mem[wr_addr] <= shreg_d;
    end

    always_ff @(posedge fw_pl_clk1) begin
        if (fw_rst)
            rd_data_q <= '0;
        else
            rd_data_q <= (rd_addr < AW'(N_WORDS)) ? mem[rd_addr] : '0;
    end

    assign rd_data       = rd_data_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err_late      = err_q;
    assign bits_captured = bits_q;

endmodule

// File: tb/tb_fw_ip2_scan_out_rx.sv
// Directed sequence with random scan data against a bit-list reference of the buffer.
module tb_fw_ip2_scan_out_rx;
    import fw_ip2_pkg::*;

    logic        fw_pl_clk1 = 1'b0;
    logic        fw_rst, cfg_start, cfg_abort, bxclk_re, fw_scan_out;
    logic [9:0]  cfg_num_bits;
    logic [5:0]  cfg_sample_dly;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        busy, done, err_late;
    logic [9:0]  bits_captured;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic        drv_bits [768];
    logic [31:0] exp_mem  [24];
    bit          exp_known[24];
    logic [31:0] pat;

    fw_ip2_scan_out_rx dut (
        .fw_pl_clk1    (fw_pl_clk1),
        .fw_rst        (fw_rst),
        .cfg_start     (cfg_start),
        .cfg_abort     (cfg_abort),
        .cfg_num_bits  (cfg_num_bits),
        .cfg_sample_dly(cfg_sample_dly),
        .bxclk_re      (bxclk_re),
        .fw_scan_out   (fw_scan_out),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .busy          (busy),
        .done          (done),
        .err_late      (err_late),
        .bits_captured (bits_captured)
    );

    always #5 fw_pl_clk1 = ~fw_pl_clk1;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge fw_pl_clk1);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Data is set up 3 cycles ahead of the bxclk edge and held until the sample
    // point has passed, so any delay in range sees the intended bit.
    task automatic send_bit(input logic b, input int period, input int d, input bit dbl);
        fw_scan_out = b;
        tick();
        tick();
        bxclk_re = 1'b1;
        tick();
        bxclk_re = 1'b0;
        if (dbl) begin
            repeat (period - 1) tick();
            bxclk_re = 1'b1;
            tick();
            bxclk_re = 1'b0;
        end
        repeat ((d > period - 3) ? d : period - 3) tick();
    endtask

    task automatic begin_capture(input int num_cfg, input int d);
        cfg_num_bits   = 10'(num_cfg);
        cfg_sample_dly = 6'(d);
        cfg_start      = 1'b1;
        tick();
        cfg_start      = 1'b0;
    endtask

    task automatic fill_rand(input int n);
        for (int k = 0; k < n; k++) drv_bits[k] = 1'($urandom);
    endtask

    task automatic model_commit(input int nbits, input bit complete);
        int nw;
        logic [31:0] v;
        nw = complete ? (nbits + 31) / 32 : nbits / 32;
        for (int w = 0; w < nw; w++) begin
            v = '0;
            for (int b = 0; b < 32; b++)
                if (w * 32 + b < nbits) v[b] = drv_bits[w * 32 + b];
            exp_mem[w]   = v;
            exp_known[w] = 1'b1;
        end
    endtask

    task automatic wait_done(input string tag);
        int c;
        c = 0;
        while (done !== 1'b1 && c < 100) begin
            tick();
            c++;
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    task automatic check_mem(input string tag);
        for (int w = 0; w < 24; w++) begin
            if (exp_known[w]) begin
                rd_addr = 5'(w);
                tick();
                chk($sformatf("%s_w%0d", tag, w), rd_data, exp_mem[w]);
            end
        end
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"},  32'(err_late), 32'd0);
        chk({tag, "_bits"}, 32'(bits_captured), 32'd0);
        chk({tag, "_rd"},   rd_data, 32'd0);
    endtask

    initial begin
        fw_rst = 1'b1; cfg_start = 1'b0; cfg_abort = 1'b0; bxclk_re = 1'b0;
        fw_scan_out = 1'b0; cfg_num_bits = '0; cfg_sample_dly = '0; rd_addr = '0;
        for (int w = 0; w < 24; w++) exp_known[w] = 1'b0;
        repeat (3) tick();
        check_idle_zero("reset");
        fw_rst = 1'b0;
        tick();

        // T1: fixed pattern, period 10, delay 3
        pat = 32'hA5A5_F00D;
        for (int k = 0; k < 32; k++) drv_bits[k] = pat[k];
        begin_capture(32, 3);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_done_lo", 32'(done), 32'd0);
        for (int k = 0; k < 32; k++) send_bit(drv_bits[k], 10, 3, 1'b0);
        wait_done("t1_done");
        chk("t1_bits", 32'(bits_captured), 32'd32);
        chk("t1_err", 32'(err_late), 32'd0);
        chk("t1_busy_lo", 32'(busy), 32'd0);
        model_commit(32, 1'b1);
        rd_addr = 5'd0;
        tick();
        chk("t1_word0", rd_data, 32'hA5A5_F00D);

        // T2: 40 bits, zero delay, partial last word
        fill_rand(40);
        begin_capture(40, 0);
        for (int k = 0; k < 40; k++) send_bit(drv_bits[k], 4, 0, 1'b0);
        wait_done("t2_done");
        chk("t2_bits", 32'(bits_captured), 32'd40);
        model_commit(40, 1'b1);
        check_mem("t2");
        rd_addr = 5'd1;
        tick();
        chk("t2_w1_hi", 32'(rd_data[31:8]), 32'd0);

        // T3: zero-length capture
        begin_capture(0, 0);
        chk("t3_done_c1", 32'(done), 32'd0);
        chk("t3_busy_c1", 32'(busy), 32'd0);
        tick();
        chk("t3_done_c2", 32'(done), 32'd1);
        chk("t3_busy_c2", 32'(busy), 32'd0);
        check_mem("t3");

        // T4: delay longer than the bxclk period
        fill_rand(20);
        begin_capture(20, 12);
        for (int k = 0; k < 20; k++) send_bit(drv_bits[k], 10, 12, 1'b1);
        wait_done("t4_done");
        chk("t4_err", 32'(err_late), 32'd1);
        chk("t4_bits", 32'(bits_captured), 32'd20);
        model_commit(20, 1'b1);
        check_mem("t4");

        // T5: abort after 17 bits, then a clamped full-buffer capture
        fill_rand(50);
        begin_capture(50, 2);
        for (int k = 0; k < 17; k++) send_bit(drv_bits[k], 6, 2, 1'b0);
        tick();
        tick();
        chk("t5_bits17", 32'(bits_captured), 32'd17);
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        chk("t5_abort_busy", 32'(busy), 32'd0);
        chk("t5_abort_done", 32'(done), 32'd0);
        model_commit(17, 1'b0);
        check_mem("t5a");

        fill_rand(768);
        begin_capture(1000, 1);
        for (int k = 0; k < 768; k++) begin
            if (k == 300) begin
                cfg_num_bits = 10'd8;
                cfg_start    = 1'b1;
                tick();
                cfg_start    = 1'b0;
                chk("t5_start_ignored", 32'(busy), 32'd1);
            end
            send_bit(drv_bits[k], 6, 1, 1'b0);
        end
        wait_done("t5_done");
        chk("t5_bits", 32'(bits_captured), 32'd768);
        model_commit(768, 1'b1);
        check_mem("t5b");
        rd_addr = 5'd24;
        tick();
        chk("t5_oob24", rd_data, 32'd0);
        rd_addr = 5'd31;
        tick();
        chk("t5_oob31", rd_data, 32'd0);

        cfg_num_bits = 10'd16;
        cfg_start    = 1'b1;
        cfg_abort    = 1'b1;
        tick();
        cfg_start    = 1'b0;
        cfg_abort    = 1'b0;
        chk("t5_both_busy", 32'(busy), 32'd0);
        chk("t5_both_done", 32'(done), 32'd0);

        // T6: reset mid-capture, then a clean 8-bit capture
        fill_rand(64);
        begin_capture(64, 2);
        for (int k = 0; k < 10; k++) send_bit(drv_bits[k], 6, 2, 1'b0);
        fw_rst = 1'b1;
        tick();
        check_idle_zero("t6_rst");
        fw_rst = 1'b0;
        tick();
        fill_rand(8);
        begin_capture(8, 2);
        for (int k = 0; k < 8; k++) send_bit(drv_bits[k], 6, 2, 1'b0);
        wait_done("t6_done");
        chk("t6_bits", 32'(bits_captured), 32'd8);
        model_commit(8, 1'b1);
        check_mem("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
